turbo_decode_scheduler: RTL and testbench
=========================================

Name: turbo_decode_scheduler

Overview:
- Sequences a single turbo_decode instance shared between REQ frame sources.
- Round-robin arbitration; registered one-hot grant; one-cycle in_valid pulse to the decoder; waits for out_valid or a timeout.
- Returns a tagged completion and enforces a minimum idle gap between decoder launches.
- Controls only: the y-array mux sits outside and is steered by dec_sel.

Parameters:
- REQ, 2, number of frame requesters (≥2)
- IDW, $clog2(REQ), requester index width
- TIMEOUT, 128, maximum WAIT cycles before a frame is declared lost (≥2; default > N*5 for N=17)
- GAP, 4, idle cycles forced after each response before the next launch (≥0)
- CNTW, 16, width of the diagnostic counters

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  REQ  requester i holds a frame ready for decode
- req_ready  out  REQ  one-hot, one-cycle accept pulse
- dec_sel  out  IDW  requester whose y is muxed into the decoder
- dec_in_valid  out  1  one-cycle launch pulse to turbo_decode.in_valid
- dec_out_valid  in  1  turbo_decode.out_valid
- rsp_valid  out  1  one-cycle completion pulse
- rsp_id  out  IDW  requester index of the completion
- rsp_timeout  out  1  completion ended by timeout, not out_valid
- busy  out  1  state != IDLE
- timeout_cnt  out  CNTW  saturating count of timeouts
- stray_cnt  out  CNTW  saturating count of dec_out_valid seen outside WAIT

Behaviour:
- Reset values (asynchronous, rst_n=0): state=IDLE; all outputs 0; rr_last=REQ-1, so requester 0 wins first; wait and gap counters 0.
- All outputs are registered.
- IDLE:
  - If any req_valid, grant the first set bit searching upward from rr_last+1 (mod REQ).
  - Register dec_sel and rr_last; go to LAUNCH. Otherwise stay.
- LAUNCH (exactly 1 cycle):
  - dec_in_valid=1; req_ready[dec_sel]=1.
  - Go to WAIT and clear wait_cnt.
  - Launch latency: req_valid sampled at edge t gives dec_in_valid high in cycle t..t+1.
- WAIT:
  - wait_cnt increments every cycle.
  - dec_out_valid=1 → RESPOND with rsp_timeout=0.
  - Else, if wait_cnt==TIMEOUT-1 → RESPOND with rsp_timeout=1 and timeout_cnt+1 (saturating).
  - dec_out_valid on the same edge as the timeout terminal → success; timeout_cnt unchanged.
- RESPOND (exactly 1 cycle):
  - rsp_valid=1, rsp_id=dec_sel.
  - Go to COOLDOWN if GAP>0, else IDLE.
- COOLDOWN: GAP cycles, then IDLE. No grants.
- dec_sel holds its value from grant through the end of RESPOND.
- req_valid is ignored outside IDLE.
- A requester dropping req_valid before LAUNCH still gets launched; its source must hold its frame until req_ready.
- dec_out_valid in any state other than WAIT → stray_cnt+1 (saturating); no state change.
- Counters saturate at all-ones and never wrap.
- rst_n low mid-frame → immediate IDLE; an in-flight decoder result arriving later counts as stray.
- Minimum launch-to-launch spacing: 1 (LAUNCH) + ≥1 (WAIT) + 1 (RESPOND) + GAP + 1 (IDLE) cycles.

Decomposition:
- Package turbo_sched_pkg holds:
  - typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, RESPOND, COOLDOWN} sched_state_t
  - function rr_pick(req, last) returning the next index
- Sub-module rr_arbiter: combinational round-robin pick.
  - Parameters REQ, IDW.
  - Inputs req and last; outputs grant_idx and any.
- The top holds the FSM, counters and output registers.

Test Plan:
- Single request (REQ=2): req_valid=2'b01; decoder model returns out_valid 85 cycles after in_valid → dec_in_valid 1 cycle after grant, req_ready=01, rsp_valid with rsp_id=0, rsp_timeout=0, timeout_cnt=0.
- Fairness: both req_valid held high for 6 frames → dec_sel sequence 0,1,0,1,0,1; consecutive dec_in_valid pulses ≥ latency+GAP+3 cycles apart.
- Timeout: decoder model never answers → rsp_valid exactly TIMEOUT+1 cycles after dec_in_valid with rsp_timeout=1; timeout_cnt=1. A late out_valid 10 cycles after that gives stray_cnt=1.
- Tie at the timeout edge: out_valid on the cycle wait_cnt==TIMEOUT-1 → rsp_timeout=0, timeout_cnt unchanged.
- Reset mid-WAIT: rst_n pulsed low 40 cycles after launch → outputs 0 immediately, no rsp_valid; a later out_valid gives stray_cnt=1; the next grant goes to requester 0.
- Saturation: CNTW=2 with 5 forced timeouts → timeout_cnt sticks at 3.

Source files
------------

// File: rtl/turbo_decode_scheduler_pkg.sv
// Shared types and helpers for the turbo decoder launch scheduler.
package turbo_sched_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LAUNCH   = 3'd1,
        WAIT     = 3'd2,
        RESPOND  = 3'd3,
        COOLDOWN = 3'd4
    } sched_state_t;

    // Widest requester vector the round-robin helper can search.
    localparam int unsigned RR_MAX_REQ = 32;

    // Round-robin pick: first set bit of req searching upward from last+1,
    // wrapping at n. Returns 0 when nothing is requested.
    function automatic int unsigned rr_pick(
        input logic [RR_MAX_REQ-1:0] req,
        input int unsigned           last,
        input int unsigned           n
    );
        int unsigned idx;
        int unsigned pick;
        logic        found;
        pick  = 32'd0;
        found = 1'b0;
        for (int unsigned k = 32'd1; k <= RR_MAX_REQ; k++) begin
            idx = last + k;
            if (idx >= n) begin
                idx = idx - n;
            end else begin
                idx = idx;
            end
            if ((k <= n) && !found && req[idx[4:0]]) begin
                pick  = idx;
                found = 1'b1;
            end else begin
                pick  = pick;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/turbo_decode_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the next requester after 'last'.
module rr_arbiter
    import turbo_sched_pkg::*;
#(
    parameter int REQ = 2,
    parameter int IDW = $clog2(REQ)
) (
    input  logic [REQ-1:0] req,
    input  logic [IDW-1:0] last,
    output logic [IDW-1:0] grant_idx,
    output logic           any
);

    logic [RR_MAX_REQ-1:0] req_ext_s;

    // Widen the request vector and search it from last+1 with wrap-around.
    always_comb begin
        req_ext_s          = {RR_MAX_REQ{1'b0}};
        req_ext_s[REQ-1:0] = req;
        grant_idx          = IDW'(rr_pick(req_ext_s, 32'(last), 32'(REQ)));
        any                = |req;
    end

endmodule

// File: rtl/turbo_decode_scheduler.sv
// Launch scheduler for a single shared turbo decoder: round-robin grant,
// one-cycle launch pulse, bounded wait for the result, tagged completion
// and a forced idle gap between launches.
module turbo_decode_scheduler
    import turbo_sched_pkg::*;
#(
    parameter int REQ     = 2,
    parameter int IDW     = $clog2(REQ),
    parameter int TIMEOUT = 128,
    parameter int GAP     = 4,
    parameter int CNTW    = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [REQ-1:0]  req_valid,
    output logic [REQ-1:0]  req_ready,
    output logic [IDW-1:0]  dec_sel,
    output logic            dec_in_valid,
    input  logic            dec_out_valid,
    output logic            rsp_valid,
    output logic [IDW-1:0]  rsp_id,
    output logic            rsp_timeout,
    output logic            busy,
    output logic [CNTW-1:0] timeout_cnt,
    output logic [CNTW-1:0] stray_cnt
);

    localparam int WW = $clog2(TIMEOUT);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [WW-1:0]   WAIT_LAST = WW'(TIMEOUT - 1);
    localparam logic [WW-1:0]   WAIT_INC  = WW'(1);
    localparam logic [GW-1:0]   GAP_LAST  = GW'((GAP > 0) ? (GAP - 1) : 0);
    localparam logic [GW-1:0]   GAP_INC   = GW'(1);
    localparam logic [IDW-1:0]  RR_RESET  = IDW'(REQ - 1);
    localparam logic [CNTW-1:0] CNT_MAX   = {CNTW{1'b1}};
    localparam logic [CNTW-1:0] CNT_INC   = CNTW'(1);
    localparam logic [REQ-1:0]  ONE_HOT0  = REQ'(1);

    sched_state_t    state_r;
    sched_state_t    state_nxt_s;
    logic [WW-1:0]   wait_cnt_r;
    logic [GW-1:0]   gap_cnt_r;
    logic [IDW-1:0]  rr_last_r;
    logic [IDW-1:0]  dec_sel_r;
    logic [REQ-1:0]  req_ready_r;
    logic            dec_in_valid_r;
    logic            rsp_valid_r;
    logic [IDW-1:0]  rsp_id_r;
    logic            rsp_timeout_r;
    logic            busy_r;
    logic [CNTW-1:0] timeout_cnt_r;
    logic [CNTW-1:0] stray_cnt_r;

    logic [IDW-1:0]  grant_idx_s;
    logic            grant_any_s;
    logic            timeout_hit_s;
    logic            stray_hit_s;

    rr_arbiter #(
        .REQ (REQ),
        .IDW (IDW)
    ) u_rr_arbiter (
        .req       (req_valid),
        .last      (rr_last_r),
        .grant_idx (grant_idx_s),
        .any       (grant_any_s)
    );

    // Next-state decode; a result arriving on the timeout terminal cycle wins.
    always_comb begin
        state_nxt_s   = state_r;
        timeout_hit_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (grant_any_s) begin
                    state_nxt_s = LAUNCH;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LAUNCH: begin
                state_nxt_s = WAIT;
            end
            WAIT: begin
                if (dec_out_valid) begin
                    state_nxt_s = RESPOND;
                end else if (wait_cnt_r == WAIT_LAST) begin
                    state_nxt_s   = RESPOND;
                    timeout_hit_s = 1'b1;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            RESPOND: begin
                if (GAP > 0) begin
                    state_nxt_s = COOLDOWN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            COOLDOWN: begin
                if (gap_cnt_r == GAP_LAST) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = COOLDOWN;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
        stray_hit_s = dec_out_valid && (state_r != WAIT);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Wait-for-result and cooldown cycle counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_r <= {WW{1'b0}};
            gap_cnt_r  <= {GW{1'b0}};
        end else begin
            case (state_r)
                LAUNCH:   wait_cnt_r <= {WW{1'b0}};
                WAIT:     wait_cnt_r <= wait_cnt_r + WAIT_INC;
                default:  wait_cnt_r <= wait_cnt_r;
            endcase
            case (state_r)
                RESPOND:  gap_cnt_r <= {GW{1'b0}};
                COOLDOWN: gap_cnt_r <= gap_cnt_r + GAP_INC;
                default:  gap_cnt_r <= gap_cnt_r;
            endcase
        end
    end

    // Capture the granted requester; it steers the y mux until the next grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last_r <= RR_RESET;
            dec_sel_r <= {IDW{1'b0}};
        end else if ((state_r == IDLE) && grant_any_s) begin
            rr_last_r <= grant_idx_s;
            dec_sel_r <= grant_idx_s;
        end else begin
            rr_last_r <= rr_last_r;
            dec_sel_r <= dec_sel_r;
        end
    end

    // Registered handshake pulses, decoded from the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready_r    <= {REQ{1'b0}};
            dec_in_valid_r <= 1'b0;
            rsp_valid_r    <= 1'b0;
            rsp_id_r       <= {IDW{1'b0}};
            rsp_timeout_r  <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            req_ready_r    <= (state_nxt_s == LAUNCH) ? (ONE_HOT0 << grant_idx_s) : {REQ{1'b0}};
            dec_in_valid_r <= (state_nxt_s == LAUNCH);
            rsp_valid_r    <= (state_nxt_s == RESPOND);
            rsp_id_r       <= (state_nxt_s == RESPOND) ? dec_sel_r : {IDW{1'b0}};
            rsp_timeout_r  <= timeout_hit_s;
            busy_r         <= (state_nxt_s != IDLE);
        end
    end

    // Saturating diagnostic counters for lost frames and unexpected results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_cnt_r <= {CNTW{1'b0}};
            stray_cnt_r   <= {CNTW{1'b0}};
        end else begin
            if (timeout_hit_s && (timeout_cnt_r != CNT_MAX)) begin
                timeout_cnt_r <= timeout_cnt_r + CNT_INC;
            end else begin
                timeout_cnt_r <= timeout_cnt_r;
            end
            if (stray_hit_s && (stray_cnt_r != CNT_MAX)) begin
                stray_cnt_r <= stray_cnt_r + CNT_INC;
            end else begin
                stray_cnt_r <= stray_cnt_r;
            end
        end
    end

    assign req_ready    = req_ready_r;
    assign dec_sel      = dec_sel_r;
    assign dec_in_valid = dec_in_valid_r;
    assign rsp_valid    = rsp_valid_r;
    assign rsp_id       = rsp_id_r;
    assign rsp_timeout  = rsp_timeout_r;
    assign busy         = busy_r;
    assign timeout_cnt  = timeout_cnt_r;
    assign stray_cnt    = stray_cnt_r;

endmodule

// File: tb/tb_turbo_decode_scheduler.sv
// Directed bench for turbo_decode_scheduler: a table of frames with a
// decoder-latency model, plus reset-mid-wait and counter-saturation sequences.
module tb_turbo_decode_scheduler;

    localparam int TIMEOUT = 128;
    localparam int GAP     = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic        dec_sel;
    logic        dec_in_valid;
    logic        dec_out_valid;
    logic        rsp_valid;
    logic        rsp_id;
    logic        rsp_timeout;
    logic        busy;
    logic [15:0] timeout_cnt;
    logic [15:0] stray_cnt;

    logic        s_rst_n;
    logic [1:0]  s_req_valid;
    logic [1:0]  s_req_ready;
    logic        s_dec_sel;
    logic        s_dec_in_valid;
    logic        s_dec_out_valid;
    logic        s_rsp_valid;
    logic        s_rsp_id;
    logic        s_rsp_timeout;
    logic        s_busy;
    logic [1:0]  s_timeout_cnt;
    logic [1:0]  s_stray_cnt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    turbo_decode_scheduler #(
        .REQ(2), .IDW(1), .TIMEOUT(TIMEOUT), .GAP(GAP), .CNTW(16)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .dec_sel(dec_sel), .dec_in_valid(dec_in_valid), .dec_out_valid(dec_out_valid),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_timeout(rsp_timeout),
        .busy(busy), .timeout_cnt(timeout_cnt), .stray_cnt(stray_cnt)
    );

    turbo_decode_scheduler #(
        .REQ(2), .IDW(1), .TIMEOUT(4), .GAP(1), .CNTW(2)
    ) u_sat (
        .clk(clk), .rst_n(s_rst_n), .req_valid(s_req_valid), .req_ready(s_req_ready),
        .dec_sel(s_dec_sel), .dec_in_valid(s_dec_in_valid), .dec_out_valid(s_dec_out_valid),
        .rsp_valid(s_rsp_valid), .rsp_id(s_rsp_id), .rsp_timeout(s_rsp_timeout),
        .busy(s_busy), .timeout_cnt(s_timeout_cnt), .stray_cnt(s_stray_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic expire(input string name);
        total++;
        bad++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    // lat = decoder answer delay in cycles after in_valid (0 = never answers)
    typedef struct {
        logic [1:0] req;
        int hold;
        int lat;
        int sel;
        int to;
        int tcnt;
        int late;
        int stray;
        int chk_gap;
    } vec_t;

    vec_t vecs[11];

    initial begin
        vec_t       v;
        int         n;
        int         cnt;
        int         got;
        int         exp_c;
        int         launch_c;
        int         prev_launch;
        int         prev_lat;
        logic [1:0] exp_rr;

        //             req   hold lat  sel to tcnt late stray gap
        vecs[0]  = '{2'b01, 0,   85,  0,  0, 0,   0,   0,    0};
        vecs[1]  = '{2'b11, 1,   5,   1,  0, 0,   0,   0,    0};
        vecs[2]  = '{2'b11, 1,   5,   0,  0, 0,   0,   0,    1};
        vecs[3]  = '{2'b11, 1,   5,   1,  0, 0,   0,   0,    1};
        vecs[4]  = '{2'b11, 1,   5,   0,  0, 0,   0,   0,    1};
        vecs[5]  = '{2'b11, 1,   5,   1,  0, 0,   0,   0,    1};
        vecs[6]  = '{2'b11, 1,   5,   0,  0, 0,   0,   0,    1};
        vecs[7]  = '{2'b01, 0,   0,   0,  1, 1,   1,   1,    0};
        vecs[8]  = '{2'b10, 0,   128, 1,  0, 1,   0,   1,    0};
        vecs[9]  = '{2'b11, 0,   127, 0,  0, 1,   0,   1,    0};
        vecs[10] = '{2'b11, 0,   1,   1,  0, 1,   0,   1,    0};

        rst_n           = 1'b0;
        req_valid       = 2'b00;
        dec_out_valid   = 1'b0;
        s_rst_n         = 1'b0;
        s_req_valid     = 2'b01;
        s_dec_out_valid = 1'b0;
        prev_launch     = 0;
        prev_lat        = 0;

        repeat (2) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_req_ready", req_ready, 0);
        check("reset_dec_in_valid", dec_in_valid, 0);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_dec_sel", dec_sel, 0);
        check("reset_timeout_cnt", timeout_cnt, 0);
        check("reset_stray_cnt", stray_cnt, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_busy", busy, 0);

        for (int i = 0; i < 11; i++) begin
            v = vecs[i];
            req_valid = v.req;
            n = 0;
            while (dec_in_valid !== 1'b1 && n < 60) begin
                @(negedge clk);
                n++;
            end
            if (dec_in_valid !== 1'b1) begin
                expire($sformatf("launch_wait row%0d", i));
                req_valid = 2'b00;
                continue;
            end
            launch_c = cyc;
            if (i == 0) check("launch_latency", n, 1);
            exp_rr = 2'b01 << v.sel;
            check($sformatf("req_ready row%0d", i), req_ready, exp_rr);
            check($sformatf("dec_sel row%0d", i), dec_sel, v.sel);
            check($sformatf("busy row%0d", i), busy, 1);
            if (v.chk_gap != 0)
                check($sformatf("launch_spacing row%0d", i), launch_c - prev_launch, prev_lat + GAP + 3);
            if (v.hold == 0) req_valid = 2'b00;

            got = 0;
            cnt = 0;
            while (got == 0 && cnt < TIMEOUT + 20) begin
                @(negedge clk);
                cnt++;
                if (cnt == 1) begin
                    check($sformatf("in_valid_pulse row%0d", i), dec_in_valid, 0);
                    check($sformatf("dec_sel_hold row%0d", i), dec_sel, v.sel);
                end
                if (rsp_valid === 1'b1) begin
                    got = 1;
                    dec_out_valid = 1'b0;
                end else begin
                    dec_out_valid = (v.lat != 0 && cnt == v.lat);
                end
            end
            dec_out_valid = 1'b0;
            exp_c = (v.lat == 0 || v.lat > TIMEOUT) ? TIMEOUT + 1 : v.lat + 1;
            if (got == 0) begin
                expire($sformatf("rsp_wait row%0d", i));
            end else begin
                check($sformatf("rsp_latency row%0d", i), cnt, exp_c);
                check($sformatf("rsp_id row%0d", i), rsp_id, v.sel);
                check($sformatf("rsp_timeout row%0d", i), rsp_timeout, v.to);
                check($sformatf("timeout_cnt row%0d", i), timeout_cnt, v.tcnt);
            end
            if (v.late != 0) begin
                repeat (10) @(negedge clk);
                dec_out_valid = 1'b1;
                @(negedge clk);
                dec_out_valid = 1'b0;
                check($sformatf("late_busy row%0d", i), busy, 0);
            end
            check($sformatf("stray_cnt row%0d", i), stray_cnt, v.stray);
            prev_launch = launch_c;
            prev_lat    = exp_c - 1;
        end

        // Reset asserted while a frame is outstanding.
        req_valid = 2'b10;
        n = 0;
        while (dec_in_valid !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (dec_in_valid !== 1'b1) expire("rst_launch_wait");
        check("rst_pre_sel", dec_sel, 1);
        req_valid = 2'b00;
        repeat (40) @(negedge clk);
        check("rst_pre_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_dec_sel", dec_sel, 0);
        check("rst_timeout_cnt", timeout_cnt, 0);
        check("rst_stray_cnt", stray_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        got = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) got++;
        end
        check("rst_no_rsp", got, 0);
        dec_out_valid = 1'b1;
        @(negedge clk);
        dec_out_valid = 1'b0;
        @(negedge clk);
        check("rst_late_stray", stray_cnt, 1);
        check("rst_late_busy", busy, 0);
        req_valid = 2'b11;
        n = 0;
        while (dec_in_valid !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (dec_in_valid !== 1'b1) expire("post_rst_launch_wait");
        check("post_rst_sel", dec_sel, 0);
        check("post_rst_req_ready", req_ready, 1);
        req_valid = 2'b00;

        // Saturation: small instance with a decoder that never answers.
        s_rst_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            n = 0;
            while (s_rsp_valid !== 1'b1 && n < 40) begin
                @(negedge clk);
                n++;
            end
            if (s_rsp_valid !== 1'b1) begin
                expire($sformatf("sat_rsp_wait %0d", k));
            end else begin
                check($sformatf("sat_rsp_timeout %0d", k), s_rsp_timeout, 1);
                check($sformatf("sat_timeout_cnt %0d", k), s_timeout_cnt, (k > 3) ? 3 : k);
            end
            @(negedge clk);
        end
        check("sat_stray_cnt", s_stray_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
